// File: rtl/tape_encoder.sv
// tape_encoder -- cassette output encoder.
//
// Takes bytes through a valid/ready handshake. One byte can wait in a holding
// buffer while another is being shifted out. Each byte goes out MSB first as a
// pulse-position waveform:
//   - every bit cell starts with a clock pulse of PULSE ticks;
//   - a '1' bit adds a data pulse of PULSE ticks at mid-cell.
// The waveform only advances on clocks where ce=1.
//
// Parameters
//   CELL   ce ticks per bit cell (even, >= 4)
//   PULSE  ce ticks per pulse (1 <= PULSE < CELL/2)
//
// Ports
//   clock  in   system clock, all logic on posedge
//   reset  in   synchronous active-high reset
//   ce     in   tick enable for the waveform timing
//   d      in   byte to send
//   valid  in   d is offered this clock
//   ready  out  holding buffer empty; byte accepted when valid && ready
//   busy   out  buffer full or shifter active
//   tape   out  encoded waveform (registered)

module tape_encoder #(
   parameter int CELL  = 1760,
   parameter int PULSE = 220
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ce,
   input  logic [7:0] d,
   input  logic       valid,
   output logic       ready,
   output logic       busy,
   output logic       tape
);

   // Tick counter is at least 16 bits wide, wider only if CELL needs it.
   localparam int TW = ($clog2(CELL) > 16) ? $clog2(CELL) : 16;

   localparam logic [TW-1:0] CELL_LAST = TW'(CELL - 1);
   localparam logic [TW-1:0] PULSE_T   = TW'(PULSE);
   localparam logic [TW-1:0] HALF_T    = TW'(CELL / 2);
   localparam logic [TW-1:0] HALF_END  = TW'(CELL / 2 + PULSE);

   typedef enum logic {IDLE, SEND} state_t;

   state_t          state_reg;
   logic [7:0]      hold_reg;
   logic            hold_full_reg;
   logic [7:0]      sh_reg;
   logic [2:0]      bit_reg;
   logic [TW-1:0]   tick_reg;
   logic            tape_reg;

   logic [TW-1:0]   tick_next;
   logic            wave_next;
   logic [7:0]      sh_shifted;

   // Shifter contents after a left shift by one (zero fill).
   assign sh_shifted[0] = 1'b0;
   generate
      for (genvar gi = 1; gi < 8; gi++) begin : g_shift
         assign sh_shifted[gi] = sh_reg[gi-1];
      end
   endgenerate

   // The waveform level is decided from the tick the counter is about to
   // enter, so the registered tape lines up with that tick.
   always_comb begin
      tick_next = (tick_reg == CELL_LAST) ? '0 : tick_reg + TW'(1);
      wave_next = 1'b0;
      if (tick_next < PULSE_T)
         wave_next = 1'b1;
      else if (tick_next >= HALF_T && tick_next < HALF_END)
         wave_next = sh_reg[7];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg     <= IDLE;
         hold_reg      <= '0;
         hold_full_reg <= 1'b0;
         sh_reg        <= '0;
         bit_reg       <= '0;
         tick_reg      <= '0;
         tape_reg      <= 1'b0;
      end else begin
         // Accept runs on every clock. It requires an empty buffer while the
         // transfer below requires a full one, so they never collide.
         if (valid && !hold_full_reg) begin
            hold_reg      <= d;
            hold_full_reg <= 1'b1;
         end

         if (ce) begin
            case (state_reg)
               IDLE: begin
                  tape_reg <= 1'b0;
                  if (hold_full_reg) begin
                     sh_reg        <= hold_reg;
                     hold_full_reg <= 1'b0;
                     bit_reg       <= 3'd7;
                     tick_reg      <= '0;
                     state_reg     <= SEND;
                     tape_reg      <= 1'b1;
                  end
               end

               SEND: begin
                  tick_reg <= tick_next;
                  tape_reg <= wave_next;
                  if (tick_reg == CELL_LAST) begin
                     if (bit_reg != 3'd0) begin
                        sh_reg  <= sh_shifted;
                        bit_reg <= bit_reg - 3'd1;
                     end else if (hold_full_reg) begin
                        // Chain straight into the next byte with no gap.
                        sh_reg        <= hold_reg;
                        hold_full_reg <= 1'b0;
                        bit_reg       <= 3'd7;
                        tape_reg      <= 1'b1;
                     end else begin
                        state_reg <= IDLE;
                        tape_reg  <= 1'b0;
                     end
                  end
               end

               default: state_reg <= IDLE;
            endcase
         end
      end
   end

   assign ready = !hold_full_reg;
   assign busy  = hold_full_reg || (state_reg == SEND);
   assign tape  = tape_reg;

endmodule

// File: tb/tb_tape_encoder.sv
// Testbench for tape_encoder (CELL=16, PULSE=2).
// The reference model turns each byte into its full list of 128 expected tape
// samples (one per ce tick) and plays that list back. The outputs are compared
// with the model after every clock.

module tb_tape_encoder;

   localparam int CELL  = 16;
   localparam int PULSE = 2;

   logic       clock;
   logic       reset;
   logic       ce;
   logic [7:0] d;
   logic       valid;
   logic       ready;
   logic       busy;
   logic       tape;

   tape_encoder #(.CELL(CELL), .PULSE(PULSE)) dut (
      .clock (clock),
      .reset (reset),
      .ce    (ce),
      .d     (d),
      .valid (valid),
      .ready (ready),
      .busy  (busy),
      .tape  (tape)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Reference model state.
   logic       wave_q[$];
   logic       m_hf;
   logic [7:0] m_hold;
   logic       m_send;
   logic       exp_tape;
   logic       m_accepted;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   // Expected waveform of one byte: clock pulse at the start of each cell,
   // data pulse at mid-cell for '1' bits, MSB first.
   task automatic push_wave(input logic [7:0] b);
      for (int k = 0; k < 8 * CELL; k++) begin
         int tk;
         int bi;
         tk = k % CELL;
         bi = 7 - k / CELL;
         wave_q.push_back((tk < PULSE) || (b[bi] && tk >= CELL/2 && tk < CELL/2 + PULSE));
      end
   endtask

   function automatic logic ce4();
      return (cyc % 4) == 3;
   endfunction

   // One clock: drive inputs, advance the model at the edge, check outputs.
   task automatic tick_clk(input logic ce_i, input logic valid_i,
                           input logic [7:0] d_i, input logic reset_i);
      logic acc;
      logic xfer;
      ce    = ce_i;
      valid = valid_i;
      d     = d_i;
      reset = reset_i;
      @(posedge clock);
      m_accepted = 1'b0;
      if (reset_i) begin
         wave_q.delete();
         m_hf     = 1'b0;
         m_send   = 1'b0;
         exp_tape = 1'b0;
      end else begin
         acc  = valid_i && !m_hf;
         xfer = ce_i && (wave_q.size() == 0) && m_hf;
         if (ce_i) begin
            if (xfer) push_wave(m_hold);
            if (wave_q.size() > 0) begin
               exp_tape = wave_q.pop_front();
               m_send   = 1'b1;
            end else begin
               exp_tape = 1'b0;
               m_send   = 1'b0;
            end
         end
         if (xfer) m_hf = 1'b0;
         if (acc) begin
            m_hold     = d_i;
            m_hf       = 1'b1;
            m_accepted = 1'b1;
            $display("accept byte=%02h cyc=%0d", d_i, cyc);
         end
      end
      #1;
      cyc++;
      check_eq("ready", 32'(ready), 32'(!m_hf));
      check_eq("busy",  32'(busy),  32'(m_hf || m_send));
      check_eq("tape",  32'(tape),  32'(exp_tape));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick_clk(ce4(), 1'b0, 8'($urandom), 1'b0);
   endtask

   // Offer a byte until the model says it was taken; bounded.
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      m_accepted = 1'b0;
      while (!m_accepted && n < 3000) begin
         tick_clk(ce4(), 1'b1, b, 1'b0);
         n++;
      end
      check_eq("accept_timeout", 32'(m_accepted), 32'd1);
   endtask

   initial begin
      reset = 1'b1;
      ce    = 1'b0;
      valid = 1'b0;
      d     = 8'h00;
      m_hf = 1'b0; m_hold = 8'h00; m_send = 1'b0; exp_tape = 1'b0; m_accepted = 1'b0;

      // Reset state
      for (int i = 0; i < 3; i++) tick_clk(ce4(), 1'b0, 8'h00, 1'b1);
      $display("reset done cyc=%0d", cyc);

      // Single byte from reset
      send_byte(8'hA5);
      idle(8 * CELL * 4 + 16);

      // Back-to-back: second byte accepted while first shifts
      send_byte(8'hFF);
      idle(20);
      send_byte(8'h00);
      idle(2 * 8 * CELL * 4 + 16);

      // Handshake rejection: 0x3C offered while buffer full
      send_byte(8'h11);
      idle(8);
      send_byte(8'h22);
      send_byte(8'h3C);
      idle(3 * 8 * CELL * 4 + 16);

      // Clock-enable freeze mid-cell
      send_byte(8'hC3);
      idle(4 * 21 + 2);
      for (int i = 0; i < 50; i++) tick_clk(1'b0, 1'b0, 8'h00, 1'b0);
      idle(8 * CELL * 4 + 16);

      // Reset at cell tick 9 of bit 4 with a byte buffered
      send_byte(8'h5A);
      send_byte(8'h77);
      begin
         int n;
         n = 0;
         while (!(m_send && wave_q.size() == 8 * CELL - 58) && n < 2000) begin
            idle(1);
            n++;
         end
         check_eq("reach_bit4", 32'(wave_q.size()), 32'(8 * CELL - 58));
      end
      tick_clk(1'b1, 1'b0, 8'h00, 1'b1);
      $display("reset mid-byte cyc=%0d", cyc);
      send_byte(8'h81);
      idle(8 * CELL * 4 + 16);

      // Boundary: only the last cell carries a data pulse
      send_byte(8'h01);
      idle(8 * CELL * 4 + 16);

      // Randomized traffic with random ce and rare resets
      for (int i = 0; i < 6000; i++) begin
         tick_clk($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                  8'($urandom), $urandom_range(0, 999) == 0);
      end
      idle(8 * CELL * 4 * 2 + 16);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
